// File: rtl/bcd_share_sched.sv
// bcd_share_sched: round-robin time-sharing of one pipelined hex->BCD converter among N_REQ
// requesters. A granted value is held on the converter input for LAT edges, then the BCD
// digits, sign and blanking count are captured into that requester's slice of the result bank.
// Optional feature: define BCD_SAT_EN to saturate |value| > 9999 to +/-9999 and add OUT_ovf.
module bcd_share_sched #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned LAT   = 3
) (
  input  logic                 IN_clk,
  input  logic                 IN_rst_n,
  input  logic [N_REQ-1:0]     IN_req,
  input  logic [16*N_REQ-1:0]  IN_hex,
  input  logic [3*N_REQ-1:0]   IN_off_number,
  output logic [N_REQ-1:0]     OUT_ack,
  output logic [15:0]          OUT_bcd_hex,
  output logic [2:0]           OUT_bcd_off,
  input  logic [15:0]          IN_bcd_dec,
  output logic [16*N_REQ-1:0]  OUT_dec,
  output logic [N_REQ-1:0]     OUT_neg,
  output logic [3*N_REQ-1:0]   OUT_off_number,
  output logic [N_REQ-1:0]     OUT_valid,
  output logic [N_REQ-1:0]     OUT_done,
  output logic                 OUT_busy
`ifdef BCD_SAT_EN
  ,
  output logic [N_REQ-1:0]     OUT_ovf
`endif
);

  localparam int unsigned PtrW = $clog2(N_REQ);
  localparam int unsigned CntW = $clog2(LAT + 1);

  localparam logic [PtrW-1:0] PtrLast = PtrW'(N_REQ - 1);
  localparam logic [CntW-1:0] CntLast = CntW'(LAT);

  localparam logic [0:0] StIdle = 1'b0;
  localparam logic [0:0] StBusy = 1'b1;

  logic [0:0]      state_q;
  logic [PtrW-1:0] ptr_q;
  logic [CntW-1:0] cnt_q;
  logic            neg_q;

  logic            grant_vld;
  logic [PtrW-1:0] grant_idx;
  logic [15:0]     sel_hex;
  logic [2:0]      sel_off;
  logic [15:0]     issue_hex;

`ifdef BCD_SAT_EN
  logic            ovf_q;
  logic            sat;
`endif

  // Round-robin search: first requester above the last grant, wrapping by explicit compare.
  always_comb begin
    logic [PtrW-1:0] idx;
    grant_vld = 1'b0;
    grant_idx = '0;
    idx       = ptr_q;
    for (int k = 0; k < int'(N_REQ); k++) begin
      idx = (idx == PtrLast) ? '0 : idx + 1'b1;
      if (!grant_vld && IN_req[idx]) begin
        grant_vld = 1'b1;
        grant_idx = idx;
      end
    end
  end

  // Select the winner's operand and, when enabled, clamp it to the 4-digit range.
  always_comb begin
    sel_hex   = IN_hex[16*grant_idx +: 16];
    sel_off   = IN_off_number[3*grant_idx +: 3];
    issue_hex = sel_hex;
`ifdef BCD_SAT_EN
    sat = ($signed(sel_hex) > 16'sd9999) || ($signed(sel_hex) < -16'sd9999);
    if (sat) begin
      // +9999 or -9999; the converter takes the magnitude itself.
      issue_hex = sel_hex[15] ? 16'hD8F1 : 16'h270F;
    end
`endif
  end

  // Grant / hold / capture sequencer and result bank.
  always_ff @(posedge IN_clk or negedge IN_rst_n) begin
    if (!IN_rst_n) begin
      state_q        <= StIdle;
      ptr_q          <= PtrLast;
      cnt_q          <= '0;
      neg_q          <= 1'b0;
      OUT_ack        <= '0;
      OUT_bcd_hex    <= '0;
      OUT_bcd_off    <= '0;
      OUT_dec        <= '0;
      OUT_neg        <= '0;
      OUT_off_number <= '0;
      OUT_valid      <= '0;
      OUT_done       <= '0;
      OUT_busy       <= 1'b0;
`ifdef BCD_SAT_EN
      ovf_q          <= 1'b0;
      OUT_ovf        <= '0;
`endif
    end else begin
      OUT_ack  <= '0;
      OUT_done <= '0;
      case (state_q)
        StIdle: begin
          if (grant_vld) begin
            OUT_ack[grant_idx] <= 1'b1;
            OUT_bcd_hex        <= issue_hex;
            OUT_bcd_off        <= sel_off;
            neg_q              <= sel_hex[15];
            ptr_q              <= grant_idx;
            cnt_q              <= '0;
            OUT_busy           <= 1'b1;
            state_q            <= StBusy;
`ifdef BCD_SAT_EN
            ovf_q              <= sat;
`endif
          end
        end
        StBusy: begin
          if (cnt_q == CntLast) begin
            // ptr_q still names the requester being served.
            OUT_dec[16*ptr_q +: 16]       <= IN_bcd_dec;
            OUT_neg[ptr_q]                <= neg_q;
            OUT_off_number[3*ptr_q +: 3]  <= OUT_bcd_off;
            OUT_valid[ptr_q]              <= 1'b1;
            OUT_done[ptr_q]               <= 1'b1;
            OUT_busy                      <= 1'b0;
            state_q                       <= StIdle;
`ifdef BCD_SAT_EN
            OUT_ovf[ptr_q]                <= ovf_q;
`endif
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
